axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares the core's single AXI read channel (AR/R) between two requesters:
//  port 0 = instruction fetch (icache refill/uncached), port 1 = data (dcache refill/uncached load).
//  Round-robin grant, exactly one burst in flight; R beats are routed back to the granted port.
//  Sits between the cache refill engines and the core's top-level AXI read master ports.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width (rdata / resp_data)
//  ID0      4'd0 arid driven for port 0 bursts
//  ID1      4'd1 arid driven for port 1 bursts
// PORTS
//  aclk        in   1       clock, all logic on rising edge
//  areset      in   1       synchronous reset, active-high
//  req_valid   in   2       per-port burst request
//  req_ready   out  2       per-port accept (one-hot or 0)
//  req_addr    in   2*ADDR_W per-port start address ([ADDR_W-1:0] = port 0)
//  req_len     in   2*8     per-port AXI arlen (beats-1)
//  req_size    in   2*3     per-port AXI arsize
//  resp_valid  out  2       per-port read beat valid
//  resp_ready  in   2       per-port read beat accept
//  resp_data   out  DATA_W  read beat data (shared, qualified by resp_valid)
//  resp_last   out  1       last beat of burst
//  resp_err    out  1       rresp != 2'b00 on current beat
//  arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI AR
//  arready     in   1
//  rid/rdata/rresp/rlast/rvalid  in  AXI R;  rready  out  1
// BEHAVIOUR
//  - FSM: IDLE -> ADDR -> DATA -> IDLE. Reset: state=IDLE, last_grant=1 (port 0 wins first tie),
//    arvalid=0, rready=0, req_ready=0, resp_valid=0; AR payload regs cleared to 0.
//  - IDLE: if any req_valid, grant = RR pick (port != last_grant preferred when both valid);
//    req_ready[grant]=1 combinationally this cycle; latch addr/len/size/owner; next ADDR.
//    Request accepted on req_valid&req_ready; requester may drop/change payload afterwards.
//  - ADDR: arvalid=1, AR payload from latched regs, arid=owner?ID1:ID0; payload stable while
//    arvalid&!arready (AXI rule). On arready -> DATA. req_ready=0 in ADDR and DATA.
//  - DATA: rready = resp_ready[owner]; resp_valid[owner]=rvalid, other port 0; resp_data=rdata,
//    resp_last=rlast, resp_err=|rresp. Beat transfers on rvalid&rready. On final beat
//    (rvalid&rready&rlast) -> IDLE, last_grant<=owner. rid not checked (single outstanding).
//  - Constants: arburst=2'b01 (INCR), arlock=0, arcache=0, arprot=0.
//  - Minimum latency: request accept to arvalid = 1 cycle; last beat to next grant = 1 cycle.
//  - Back-to-back: new grant only from IDLE; no AR issued before previous burst's rlast.
//  - Fairness: with both ports continuously requesting, grants alternate 0,1,0,1...
//  - areset mid-burst: FSM returns to IDLE next edge; outstanding AXI beats are not drained
//    (whole core is reset together).
//  - No combinational path from arready/rvalid to req_ready.
// TESTING
//  1 reset, port0 req addr=0x1c000000 len=7 -> req_ready[0] same cycle, arvalid next cycle,
//    araddr=0x1c000000 arlen=7 arid=0; 8 beats to resp_valid[0], resp_last on 8th only.
//  2 both ports request same cycle after reset -> port0 granted first; after its rlast,
//    port1 granted next idle cycle (arid=1); repeat -> strict alternation over 6 bursts.
//  3 arready held low 5 cycles -> arvalid stays 1, araddr/arlen/arsize unchanged, no req_ready.
//  4 resp_ready[owner] toggles 1010 during burst len=3 -> rready mirrors it, 4 beats in order,
//    no beat lost or duplicated, other port's resp_valid always 0.
//  5 rresp=2'b10 on beat 2 of 4 -> resp_err=1 on that beat only; burst completes normally.
//  6 areset asserted in DATA after beat 1 -> arvalid=0, rready=0, req_ready=0 next cycle;
//    new port1 request afterwards granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// AXI read-channel arbiter: round-robin between instruction fetch (port 0) and data (port 1),
// one burst in flight, R beats steered back to the port that owns the burst.
module axi_rd_arbiter #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [3:0] ID0    = 4'd0,
    parameter logic [3:0] ID1    = 4'd1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [15:0]           req_len,
    input  logic [5:0]            req_size,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_last,
    output logic                  resp_err,
    output logic [3:0]            arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [3:0]            rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            state_r;
    logic              last_grant_r;
    logic              owner_r;
    logic              arvalid_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        len_r;
    logic [2:0]        size_r;

    logic grant_s;
    logic accept_s;
    logic beat_s;
    logic unused_s;

    // Round-robin pick: on a tie the port not served last wins
    always_comb begin
        grant_s = 1'b0;
        if (req_valid == 2'b11) begin
            grant_s = ~last_grant_r;
        end else begin
            grant_s = req_valid[1];
        end
    end

    // Grant offered only while idle; depends on registered state and req_valid only
    always_comb begin
        req_ready = 2'b00;
        if ((state_r == ST_IDLE) && (req_valid != 2'b00)) begin
            req_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Steer the R beat valid to the owning port only
    always_comb begin
        resp_valid = 2'b00;
        if (state_r == ST_DATA) begin
            resp_valid = owner_r ? {rvalid, 1'b0} : {1'b0, rvalid};
        end else begin
            resp_valid = 2'b00;
        end
    end

    assign accept_s = |(req_valid & req_ready);
    assign rready   = (state_r == ST_DATA) & resp_ready[owner_r];
    assign beat_s   = (state_r == ST_DATA) & rvalid & rready;

    // Burst FSM; the AR payload is latched at grant so the requester may move on
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            arvalid_r    <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            len_r        <= 8'd0;
            size_r       <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r   <= grant_s;
                        addr_r    <= grant_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                        len_r     <= grant_s ? req_len[15:8] : req_len[7:0];
                        size_r    <= grant_s ? req_size[5:3] : req_size[2:0];
                        arvalid_r <= 1'b1;
                        state_r   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready) begin
                        arvalid_r <= 1'b0;
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_s && rlast) begin
                        last_grant_r <= owner_r;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign arid      = owner_r ? ID1 : ID0;
    assign araddr    = addr_r;
    assign arlen     = len_r;
    assign arsize    = size_r;
    assign arvalid   = arvalid_r;
    assign arburst   = 2'b01;
    assign arlock    = 1'b0;
    assign arcache   = 4'b0000;
    assign arprot    = 3'b000;

    assign resp_data = rdata;
    assign resp_last = rlast;
    assign resp_err  = |rresp;

    // Only one burst is ever outstanding, so the returned ID carries no information
    assign unused_s  = ^rid;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter: inputs driven 1 time unit after the
// rising edge, outputs sampled on the falling edge.
module tb_axi_rd_arbiter;

    logic        aclk;
    logic        areset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [15:0] req_len;
    logic [5:0]  req_size;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        resp_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    axi_rd_arbiter dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic apply_reset();
        @(posedge aclk); #1;
        areset = 1'b1; req_valid = 2'b00; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        rresp = 2'b00; resp_ready = 2'b00;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge aclk); #1;
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b exp 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b exp 0", rready); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b exp 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid: got %b exp 00", resp_valid); end
        checks++; if ({araddr, arlen, arsize} !== 43'd0) begin errors++; $display("FAIL rst_ar_payload: got %h/%h/%h exp 0", araddr, arlen, arsize); end
        checks++; if ({arburst, arlock, arcache, arprot} !== 10'b01_0_0000_000) begin errors++; $display("FAIL rst_ar_const: got %b %b %b %b", arburst, arlock, arcache, arprot); end
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic test_single_burst();
        @(posedge aclk); #1;
        req_valid = 2'b01; req_addr = {32'h0, 32'h1c00_0000}; req_len = {8'd0, 8'd7}; req_size = {3'd0, 3'd2};
        @(negedge aclk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t1_req_ready: got %b exp 01", req_ready); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL t1_arvalid_early: got %b exp 0", arvalid); end
        @(posedge aclk); #1;
        req_valid = 2'b00; req_addr = 64'h0; req_len = 16'h0; arready = 1'b1;
        @(negedge aclk);
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL t1_arvalid: got %b exp 1", arvalid); end
        checks++; if (araddr !== 32'h1c00_0000) begin errors++; $display("FAIL t1_araddr: got %h exp 1c000000", araddr); end
        checks++; if (arlen !== 8'd7 || arsize !== 3'd2) begin errors++; $display("FAIL t1_arlen_size: got %0d/%0d exp 7/2", arlen, arsize); end
        checks++; if (arid !== 4'd0) begin errors++; $display("FAIL t1_arid: got %0d exp 0", arid); end
        @(posedge aclk); #1;
        arready = 1'b0; resp_ready = 2'b01;
        for (int b = 0; b < 8; b++) begin
            rvalid = 1'b1; rdata = 32'hD000_0000 + b; rlast = (b == 7);
            @(negedge aclk);
            checks++; if (resp_valid !== 2'b01 || rready !== 1'b1) begin errors++; $display("FAIL t1_beat%0d_valid: got %b/%b exp 01/1", b, resp_valid, rready); end
            checks++; if (resp_data !== 32'hD000_0000 + b) begin errors++; $display("FAIL t1_beat%0d_data: got %h exp %h", b, resp_data, 32'hD000_0000 + b); end
            checks++; if (resp_last !== (b == 7)) begin errors++; $display("FAIL t1_beat%0d_last: got %b exp %b", b, resp_last, (b == 7)); end
            @(posedge aclk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge aclk);
        checks++; if (rready !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL t1_idle: got rready %b arvalid %b exp 0/0", rready, arvalid); end
        resp_ready = 2'b00;
    endtask

    task automatic test_alternation();
        logic [1:0]  exp_oh;
        logic [31:0] exp_addr;
        apply_reset();
        @(posedge aclk); #1;
        req_valid = 2'b11; req_addr = {32'h2000_0000, 32'h1000_0000}; req_len = 16'h0; req_size = 6'h0;
        resp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp_oh   = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000;
            @(negedge aclk);
            checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL t2_grant%0d: got %b exp %b", k, req_ready, exp_oh); end
            @(posedge aclk); #1;
            arready = 1'b1;
            @(negedge aclk);
            checks++; if (arvalid !== 1'b1 || arid !== {3'd0, exp_oh[1]} || araddr !== exp_addr) begin errors++; $display("FAIL t2_ar%0d: got v%b id%0d %h exp id%0d %h", k, arvalid, arid, araddr, exp_oh[1], exp_addr); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL t2_busy_ready%0d: got %b exp 00", k, req_ready); end
            @(posedge aclk); #1;
            arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = k;
            @(negedge aclk);
            checks++; if (resp_valid !== exp_oh) begin errors++; $display("FAIL t2_resp%0d: got %b exp %b", k, resp_valid, exp_oh); end
            @(posedge aclk); #1;
            rvalid = 1'b0; rlast = 1'b0;
        end
        req_valid = 2'b00; resp_ready = 2'b00;
    endtask

    task automatic test_ar_stall();
        @(posedge aclk); #1;
        req_valid = 2'b10; req_addr = {32'h3000_0040, 32'h0}; req_len = {8'd3, 8'd0}; req_size = {3'd2, 3'd0};
        @(negedge aclk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL t3_req_ready: got %b exp 10", req_ready); end
        @(posedge aclk); #1;
        req_valid = 2'b11; req_addr = 64'hFFFF_FFFF_FFFF_FFFF; req_len = 16'hFFFF; req_size = 6'h3F; arready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            checks++; if (arvalid !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL t3_stall%0d: got arvalid %b req_ready %b exp 1/00", c, arvalid, req_ready); end
            checks++; if (araddr !== 32'h3000_0040 || arlen !== 8'd3 || arsize !== 3'd2) begin errors++; $display("FAIL t3_payload%0d: got %h/%0d/%0d exp 30000040/3/2", c, araddr, arlen, arsize); end
            @(posedge aclk); #1;
        end
        req_valid = 2'b00; arready = 1'b1;
        @(posedge aclk); #1;
        arready = 1'b0; resp_ready = 2'b10; rvalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            rlast = (b == 3);
            @(posedge aclk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge aclk);
        checks++; if (rready !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL t3_idle: got rready %b arvalid %b exp 0/0", rready, arvalid); end
        resp_ready = 2'b00;
    endtask

    task automatic test_resp_backpressure();
        int   idx;
        int   cyc;
        logic pat;
        @(posedge aclk); #1;
        req_valid = 2'b01; req_addr = {32'h0, 32'h0000_0100}; req_len = {8'd0, 8'd3}; req_size = 6'd2;
        @(posedge aclk); #1;
        req_valid = 2'b00; arready = 1'b1;
        @(posedge aclk); #1;
        arready = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 20) begin
            pat = (cyc % 2 == 0);
            rvalid = 1'b1; rdata = 32'hA0 + idx; rlast = (idx == 3); resp_ready = {~pat, pat};
            @(negedge aclk);
            checks++; if (rready !== pat) begin errors++; $display("FAIL t4_rready%0d: got %b exp %b", cyc, rready, pat); end
            checks++; if (resp_valid !== 2'b01 || resp_data !== 32'hA0 + idx) begin errors++; $display("FAIL t4_beat%0d: got %b %h exp 01 %h", cyc, resp_valid, resp_data, 32'hA0 + idx); end
            @(posedge aclk); #1;
            if (pat) idx++;
            cyc++;
        end
        rvalid = 1'b0; rlast = 1'b0; resp_ready = 2'b01;
        checks++; if (idx != 4 || cyc != 7) begin errors++; $display("FAIL t4_count: got %0d beats in %0d cycles exp 4 in 7", idx, cyc); end
        @(negedge aclk);
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL t4_idle: got rready %b exp 0", rready); end
        resp_ready = 2'b00;
    endtask

    task automatic test_resp_err();
        @(posedge aclk); #1;
        req_valid = 2'b10; req_addr = {32'h5000_0000, 32'h0}; req_len = {8'd3, 8'd0};
        @(posedge aclk); #1;
        req_valid = 2'b00; arready = 1'b1;
        @(posedge aclk); #1;
        arready = 1'b0; resp_ready = 2'b11;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1; rdata = 32'hE0 + b; rlast = (b == 3); rresp = (b == 1) ? 2'b10 : 2'b00;
            @(negedge aclk);
            checks++; if (resp_err !== (b == 1)) begin errors++; $display("FAIL t5_err%0d: got %b exp %b", b, resp_err, (b == 1)); end
            checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL t5_valid%0d: got %b exp 10", b, resp_valid); end
            @(posedge aclk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        @(negedge aclk);
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL t5_idle: got rready %b exp 0", rready); end
        resp_ready = 2'b00;
    endtask

    task automatic test_reset_mid_burst();
        @(posedge aclk); #1;
        req_valid = 2'b01; req_addr = {32'h0, 32'h6000_0000}; req_len = {8'd0, 8'd3};
        @(negedge aclk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t6_req_ready: got %b exp 01", req_ready); end
        @(posedge aclk); #1;
        req_valid = 2'b00; arready = 1'b1;
        @(posedge aclk); #1;
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b0; rdata = 32'h0; resp_ready = 2'b01;
        @(negedge aclk);
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL t6_beat1: got %b exp 01", resp_valid); end
        @(posedge aclk); #1;
        areset = 1'b1; rdata = 32'h1;
        @(posedge aclk);
        @(negedge aclk);
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL t6_after_rst: got arvalid %b rready %b req_ready %b exp 0/0/00", arvalid, rready, req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL t6_resp_valid: got %b exp 00", resp_valid); end
        @(posedge aclk); #1;
        areset = 1'b0; rvalid = 1'b0;
        req_valid = 2'b10; req_addr = {32'h7000_0080, 32'h0}; req_len = 16'h0;
        @(negedge aclk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL t6_regrant: got %b exp 10", req_ready); end
        @(posedge aclk); #1;
        req_valid = 2'b00; arready = 1'b1;
        @(negedge aclk);
        checks++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h7000_0080) begin errors++; $display("FAIL t6_ar: got v%b id%0d %h exp 1/1/70000080", arvalid, arid, araddr); end
        @(posedge aclk); #1;
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; resp_ready = 2'b10;
        @(negedge aclk);
        checks++; if (resp_valid !== 2'b10 || resp_last !== 1'b1) begin errors++; $display("FAIL t6_beat: got %b last %b exp 10/1", resp_valid, resp_last); end
        @(posedge aclk); #1;
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge aclk);
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL t6_idle: got arvalid %b rready %b exp 0/0", arvalid, rready); end
        resp_ready = 2'b00;
    endtask

    initial begin
        areset = 1'b0; req_valid = 2'b00; req_addr = 64'h0; req_len = 16'h0; req_size = 6'h0;
        resp_ready = 2'b00; arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00;
        rlast = 1'b0; rvalid = 1'b0;
        test_reset();
        test_single_burst();
        test_alternation();
        test_ar_stall();
        test_resp_backpressure();
        test_resp_err();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
